shift_word_rx: RTL and testbench
================================

SHIFT_WORD_RX -- requirements
Module: shift_word_rx

Interface
REQ-001 Parameter WIDTH, default 36, word length in bits (legal range 4..64).
REQ-002 Parameter MSB_FIRST, default 1; 1 places the first received bit in word[0], 0 places it in word[WIDTH-1].
REQ-003 Ports (one clock; reset is synchronous and active-low):
- clk  in  1  sole clock; all state changes on posedge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  frame begin; next qualified bit is bit 1 of a word.
- shft_en  in  1  qualifies sin on this edge.
- sin  in  1  serial data bit.
- ready  in  1  consumer accepts word this cycle.
- ovr_clr  in  1  clears overrun.
- word  out  [0:WIDTH-1]  assembled word, held while valid.
- valid  out  1  word available.
- busy  out  1  frame in progress.
- overrun  out  1  sticky; completed word dropped.
- parity_err  out  1  present only with SHIFT_WORD_RX_PARITY_EN.

Function
REQ-004 FSM states: IDLE, SHIFT, PAR (parity build only); encoding from shared package.
REQ-005 IDLE: shft_en ignored; start -> SHIFT, bit counter cleared, shift register cleared.
REQ-006 SHIFT: each shft_en captures sin into the shift register in MSB_FIRST order; counter +1.
REQ-007 start in SHIFT or PAR discards the partial word, clears the counter, stays/returns to SHIFT; sin on that same edge is not captured.
REQ-008 start and shft_en together in IDLE: start wins; the bit is not captured.
REQ-009 Completion = WIDTH-th qualified bit (no-parity build) or the parity bit (parity build); state -> IDLE on that edge.
REQ-010 word and valid update on the edge after the completing edge (one-cycle latency); busy deasserts on the completing edge.
REQ-011 valid stays high and word stays stable until ready is sampled high; ready with valid low has no effect.
REQ-012 Completion while valid=1 and ready=0: new word dropped, word unchanged, overrun set.
REQ-013 Completion in the same cycle as ready=1 with valid=1: old word consumed, new word loaded, valid stays 1, no overrun.
REQ-014 overrun is sticky; cleared only by ovr_clr or reset; ovr_clr coincident with a new overrun leaves overrun=1.
REQ-015 The counter saturates at completion and never wraps mid-frame.

Reset
REQ-016 rst_n=0 on a clk edge: state IDLE, counter 0, shift register 0, word 0, valid 0, busy 0, overrun 0, parity_err 0.
REQ-017 Reset mid-frame or with valid=1 discards all data; no output glitches to a partial word.

Configuration
REQ-018 Macro SHIFT_WORD_RX_PARITY_EN defined: one odd-parity bit follows the WIDTH data bits (state PAR); parity_err is loaded with word and set when data plus parity has even weight; it clears when the word is consumed.
REQ-019 Macro undefined: no PAR state, no parity_err port, completion at the WIDTH-th bit.

Structure
REQ-020 The shared logic package holds the FSM state enum tShRxState and the parity-kind constant; nothing block-local goes there.
REQ-021 One sub-module, shift_word_rx_cnt: saturating bit counter with clear, increment, and terminal-count output.
REQ-022 Total RTL 120-400 lines; no latches; single always_ff per register group.

Verification (WIDTH=36, MSB_FIRST=1 unless stated)
REQ-023 start, then 36 shft_en bits of 36'o123456701234 with ready=1 -> valid pulses one cycle, word=36'o123456701234, overrun=0.
REQ-024 MSB_FIRST=0, same stream -> word is the bit-reverse of 36'o123456701234.
REQ-025 Two back-to-back words with ready=0 -> first word held, overrun=1 after second completion; ovr_clr -> overrun=0, word still first.
REQ-026 start re-asserted after 20 bits, then 36 bits of 36'o777777000000 -> word=36'o777777000000, no trace of the partial word.
REQ-027 rst_n=0 after 10 bits, then a full word -> only the post-reset word appears; all outputs 0 during reset.
REQ-028 Parity build: 36'o000000000001 with parity 0 -> parity_err=0; with parity 1 -> parity_err=1.

Source files
------------

// File: rtl/shift_word_rx_pkg.sv
// Shared definitions for the serial word receiver.
// Optional build macro: SHIFT_WORD_RX_PARITY_EN (adds the PAR state).
package shift_word_rx_pkg;

`ifdef SHIFT_WORD_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} tShRxState;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} tShRxState;
`endif

  // Required XOR of data plus parity bit (odd parity scheme).
  localparam logic SHRX_PARITY_ODD = 1'b1;

endpackage

// File: rtl/shift_word_rx_cnt.sv
// Saturating bit counter: clear wins over increment, holds at WIDTH,
// tc_o flags that the next qualified bit is the last data bit.
module shift_word_rx_cnt
  import shift_word_rx_pkg::*;
#(
  parameter int WIDTH = 36
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic [CW-1:0] cnt_q, cnt_d;

  // next count: clear, or increment until saturated at WIDTH
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                        cnt_d = '0;
    else if (inc_i && cnt_q != FULL)  cnt_d = cnt_q + 1'b1;
  end

  // count register
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/shift_word_rx.sv
// Serial-to-parallel word receiver with one-word output holding register,
// sticky overrun and one-cycle completion-to-valid latency.
// Optional build macro: SHIFT_WORD_RX_PARITY_EN (odd parity bit after data,
// parity_err port).
module shift_word_rx
  import shift_word_rx_pkg::*;
#(
  parameter int WIDTH     = 36,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             shft_en,
  input  logic             sin,
  input  logic             ready,
  input  logic             ovr_clr,
  output logic [0:WIDTH-1] word,
  output logic             valid,
  output logic             busy,
`ifdef SHIFT_WORD_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             overrun
);

  tShRxState        state_q, state_d;
  logic             tc, cap, complete;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             done_q;
  logic [WIDTH-1:0] word_q;
  logic             valid_q, overrun_q;
  logic             drop, load;
`ifdef SHIFT_WORD_RX_PARITY_EN
  logic             perr_now, perr_pend_q, perr_q;
`endif

  // start always wins, so a bit presented with start is never captured
  assign cap = (state_q == SHIFT) && shft_en && !start;

`ifdef SHIFT_WORD_RX_PARITY_EN
  assign complete = (state_q == PAR) && shft_en && !start;
  assign perr_now = ((^sr_q) ^ sin) != SHRX_PARITY_ODD;
`else
  assign complete = cap && tc;
`endif

  shift_word_rx_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (start),
    .inc_i (cap),
    .tc_o  (tc)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = SHIFT;
      SHIFT: begin
        if (start)           state_d = SHIFT;
`ifdef SHIFT_WORD_RX_PARITY_EN
        else if (cap && tc)  state_d = PAR;
`else
        else if (cap && tc)  state_d = IDLE;
`endif
      end
`ifdef SHIFT_WORD_RX_PARITY_EN
      PAR: begin
        if (start)           state_d = SHIFT;
        else if (shft_en)    state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy drops on the completing edge
  always_comb begin
    busy = (state_q != IDLE);
  end

  // shift register next value; first bit ends at the word[0] end when MSB_FIRST
  always_comb begin
    sr_d = sr_q;
    if (start)    sr_d = '0;
    else if (cap) sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], sin} : {sin, sr_q[WIDTH-1:1]};
  end

  // shift register plus completion flag delayed one cycle into the output stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q   <= '0;
      done_q <= 1'b0;
`ifdef SHIFT_WORD_RX_PARITY_EN
      perr_pend_q <= 1'b0;
`endif
    end else begin
      sr_q   <= sr_d;
      done_q <= complete;
`ifdef SHIFT_WORD_RX_PARITY_EN
      if (complete) perr_pend_q <= perr_now;
`endif
    end
  end

  // A finished word is dropped only when the held word is still unconsumed;
  // ready in the load cycle frees the slot for the new word.
  assign drop = done_q && valid_q && !ready;
  assign load = done_q && !drop;

  // output holding register, valid handshake and sticky overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SHIFT_WORD_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      if (load) begin
        word_q  <= sr_q;
        valid_q <= 1'b1;
`ifdef SHIFT_WORD_RX_PARITY_EN
        perr_q  <= perr_pend_q;
`endif
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
`ifdef SHIFT_WORD_RX_PARITY_EN
        perr_q  <= 1'b0;
`endif
      end
      overrun_q <= drop | (overrun_q & ~ovr_clr);
    end
  end

  assign word    = word_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;
`ifdef SHIFT_WORD_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_shift_word_rx.sv
// Bench for shift_word_rx: two instances (MSB_FIRST=1 and 0) share inputs and
// are compared every cycle against a queue-based reference model, plus a
// vector table and directed multi-cycle sequences.
module tb_shift_word_rx;

  localparam int W = 36;

  logic clk = 1'b0;
  logic rst_n = 1'b0, start = 1'b0, shft_en = 1'b0, sin = 1'b0;
  logic ready = 1'b0, ovr_clr = 1'b0;
  logic [0:W-1] word0, word1;
  logic valid0, valid1, busy0, busy1, ovr0, ovr1;
`ifdef SHIFT_WORD_RX_PARITY_EN
  logic perr0, perr1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_word_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .shft_en(shft_en), .sin(sin),
    .ready(ready), .ovr_clr(ovr_clr), .word(word0), .valid(valid0), .busy(busy0),
`ifdef SHIFT_WORD_RX_PARITY_EN
    .parity_err(perr0),
`endif
    .overrun(ovr0));

  shift_word_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .shft_en(shft_en), .sin(sin),
    .ready(ready), .ovr_clr(ovr_clr), .word(word1), .valid(valid1), .busy(busy1),
`ifdef SHIFT_WORD_RX_PARITY_EN
    .parity_err(perr1),
`endif
    .overrun(ovr1));

  // ---------------- reference model ----------------
  bit             q[$];          // data bits of the frame in arrival order
  bit             m_busy, m_inpar, m_pend, m_valid, m_ovr, m_perr, m_pperr;
  logic [W-1:0]   m_pw0, m_pw1, m_w0, m_w1;

  function automatic logic [W-1:0] pack(input bit b[$], input bit msb);
    logic [W-1:0] v = '0;
    for (int i = 0; i < b.size(); i++)
      if (msb) v[W-1-i] = b[i]; else v[i] = b[i];
    return v;
  endfunction

  function automatic logic [W-1:0] rev(input logic [W-1:0] d);
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = d[W-1-i];
    return v;
  endfunction

  task automatic finish_frame(input bit pbit);
    int ones = 0;
    foreach (q[i]) ones += int'(q[i]);
    ones += int'(pbit);
    m_pend  = 1'b1;
    m_pw0   = pack(q, 1'b1);
    m_pw1   = pack(q, 1'b0);
    m_pperr = (ones % 2) == 0;
    m_busy  = 1'b0;
    m_inpar = 1'b0;
  endtask

  task automatic model(input bit s, input bit e, input bit d, input bit r,
                       input bit c, input bit rn);
    bit drop, pend;
    if (!rn) begin
      q.delete();
      {m_busy, m_inpar, m_pend, m_valid, m_ovr, m_perr, m_pperr} = '0;
      m_w0 = '0; m_w1 = '0;
      return;
    end
    // output stage sees the word finished on the previous edge
    pend   = m_pend;
    drop   = pend && m_valid && !r;
    if (pend && !drop) begin
      m_w0 = m_pw0; m_w1 = m_pw1; m_valid = 1'b1; m_perr = m_pperr;
    end else if (!pend && m_valid && r) begin
      m_valid = 1'b0; m_perr = 1'b0;
    end
    m_ovr  = drop || (m_ovr && !c);
    m_pend = 1'b0;
    // frame assembly
    if (s) begin
      m_busy = 1'b1; m_inpar = 1'b0; q.delete();
    end else if (m_busy && e) begin
      if (m_inpar) finish_frame(d);
      else begin
        q.push_back(d);
        if (q.size() == W) begin
`ifdef SHIFT_WORD_RX_PARITY_EN
          m_inpar = 1'b1;
`else
          finish_frame(1'b0);
`endif
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("word0",  64'(word0),  64'(m_w0));
    chk("word1",  64'(word1),  64'(m_w1));
    chk("valid0", 64'(valid0), 64'(m_valid));
    chk("valid1", 64'(valid1), 64'(m_valid));
    chk("busy0",  64'(busy0),  64'(m_busy));
    chk("busy1",  64'(busy1),  64'(m_busy));
    chk("ovr0",   64'(ovr0),   64'(m_ovr));
    chk("ovr1",   64'(ovr1),   64'(m_ovr));
`ifdef SHIFT_WORD_RX_PARITY_EN
    chk("perr0",  64'(perr0),  64'(m_perr));
    chk("perr1",  64'(perr1),  64'(m_perr));
`endif
  endtask

  // apply one cycle of inputs, advance the model, compare everything
  task automatic cyc(input bit s, input bit e, input bit d, input bit r,
                     input bit c, input bit rn);
    start = s; shft_en = e; sin = d; ready = r; ovr_clr = c; rst_n = rn;
    @(posedge clk); #1;
    model(s, e, d, r, c, rn);
    cmp_all();
  endtask

  // start plus W data bits (numeric MSB first) plus parity bit in parity builds
  task automatic send(input logic [W-1:0] data, input bit r, input bit p);
    cyc(1'b1, 1'b0, 1'b0, r, 1'b0, 1'b1);
    for (int i = W - 1; i >= 0; i--) cyc(1'b0, 1'b1, data[i], r, 1'b0, 1'b1);
`ifdef SHIFT_WORD_RX_PARITY_EN
    cyc(1'b0, 1'b1, p, r, 1'b0, 1'b1);
`endif
  endtask

  task automatic idle(input bit r);
    cyc(1'b0, 1'b0, 1'b0, r, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] exp0;
    logic [W-1:0] exp1;
  } vec_t;

  localparam logic [W-1:0] A = 36'o123456701234;
  localparam logic [W-1:0] B = 36'o777777000000;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{36'o000000000000, 36'o000000000000, 36'o000000000000};
    tbl[1] = '{36'o777777777777, 36'o777777777777, 36'o777777777777};
    tbl[2] = '{36'o400000000001, 36'o400000000001, 36'o400000000001};
    tbl[3] = '{36'o000000000001, 36'o000000000001, 36'o400000000000};
    tbl[4] = '{A, A, rev(A)};

    // reset state
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_word", 64'(word0), 64'd0);
    chk("rst_valid", 64'(valid0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_ovr", 64'(ovr0), 64'd0);

    // shft_en in IDLE is ignored; start with shft_en does not capture
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("idle_busy", 64'(busy0), 64'd0);

    // main word with ready=1: one-cycle latency, single-cycle valid pulse
    send(A, 1'b1, ~^A);
    chk("A_busy_done", 64'(busy0), 64'd0);
    chk("A_valid_lat", 64'(valid0), 64'd0);
    idle(1'b1);
    chk("A_word_msb", 64'(word0), 64'(A));
    chk("A_word_lsb", 64'(word1), 64'(rev(A)));
    chk("A_valid", 64'(valid0), 64'd1);
    chk("A_ovr", 64'(ovr0), 64'd0);
    idle(1'b1);
    chk("A_valid_pulse", 64'(valid0), 64'd0);

    // table of words
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].data, 1'b0, ~^tbl[i].data);
      idle(1'b0);
      chk($sformatf("tbl%0d_w0", i), 64'(word0), 64'(tbl[i].exp0));
      chk($sformatf("tbl%0d_w1", i), 64'(word1), 64'(tbl[i].exp1));
      chk($sformatf("tbl%0d_v", i), 64'(valid0), 64'd1);
      idle(1'b0);
      chk($sformatf("tbl%0d_hold", i), 64'(word0), 64'(tbl[i].exp0));
      idle(1'b1);
    end

    // back-to-back words with ready=0: second dropped, overrun sticky
    send(A, 1'b0, ~^A);
    idle(1'b0);
    send(B, 1'b0, ~^B);
    idle(1'b0);
    chk("ovr_set", 64'(ovr0), 64'd1);
    chk("ovr_word_kept", 64'(word0), 64'(A));
    idle(1'b0);
    chk("ovr_sticky", 64'(ovr0), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ovr_clr", 64'(ovr0), 64'd0);
    chk("ovr_clr_word", 64'(word0), 64'(A));

    // completion with ready in the load cycle: swap, no overrun
    send(B, 1'b0, ~^B);
    idle(1'b1);
    chk("swap_word", 64'(word0), 64'(B));
    chk("swap_valid", 64'(valid0), 64'd1);
    chk("swap_ovr", 64'(ovr0), 64'd0);
    idle(1'b1);

    // ovr_clr coincident with a new overrun keeps it set
    send(A, 1'b0, ~^A);
    idle(1'b0);
    send(B, 1'b0, ~^B);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ovr_clr_race", 64'(ovr0), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // restart after 20 bits
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, A[W-1-i], 1'b1, 1'b0, 1'b1);
    send(B, 1'b1, ~^B);
    idle(1'b1);
    chk("restart_w0", 64'(word0), 64'(B));
    chk("restart_w1", 64'(word1), 64'(rev(B)));

    // reset mid-frame with a valid word pending
    send(A, 1'b0, ~^A);
    idle(1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mrst_word", 64'(word0), 64'd0);
    chk("mrst_valid", 64'(valid0), 64'd0);
    chk("mrst_busy", 64'(busy0), 64'd0);
    chk("mrst_ovr", 64'(ovr0), 64'd0);
    send(B, 1'b0, ~^B);
    idle(1'b0);
    chk("post_rst_word", 64'(word0), 64'(B));
    idle(1'b1);

`ifdef SHIFT_WORD_RX_PARITY_EN
    send(36'o000000000001, 1'b0, 1'b0);
    idle(1'b0);
    chk("par_ok", 64'(perr0), 64'd0);
    idle(1'b1);
    send(36'o000000000001, 1'b0, 1'b1);
    idle(1'b0);
    chk("par_bad", 64'(perr0), 64'd1);
    idle(1'b1);
    chk("par_clr", 64'(perr0), 64'd0);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++)
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
          $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 699) != 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
